// File: rtl/me_pkg.sv
// Shared motion-estimation constants and helpers used by the SAD unit and the
// best-match comparator.
package me_pkg;

  localparam int unsigned DEF_BIT_WIDTH = 14;
  localparam int unsigned DEF_BLOCK_LEN = 16;

  // Width of a block SAD: one element plus enough headroom for len additions.
  function automatic int unsigned acc_width(input int unsigned bw, input int unsigned len);
    return bw + $clog2(len);
  endfunction

endpackage

// File: rtl/abs_diff.sv
// Combinational unsigned absolute difference |element0 - element1|.
module abs_diff #(
  parameter int unsigned BIT_WIDTH = me_pkg::DEF_BIT_WIDTH
) (
  input  logic [BIT_WIDTH-1:0] element0,
  input  logic [BIT_WIDTH-1:0] element1,
  output logic [BIT_WIDTH-1:0] element
);

  logic [BIT_WIDTH:0]   w_diff;
  logic [BIT_WIDTH-1:0] w_neg;

  // The extra top bit is the borrow: set exactly when element0 < element1.
  assign w_diff = {1'b0, element0} - {1'b0, element1};
  assign w_neg  = ~w_diff[BIT_WIDTH-1:0] + {{(BIT_WIDTH-1){1'b0}}, 1'b1};

  assign element = w_diff[BIT_WIDTH] ? w_neg : w_diff[BIT_WIDTH-1:0];

endmodule

// File: rtl/sad_accumulator.sv
// Streaming sum-of-absolute-differences over fixed blocks of BLOCK_LEN pixel
// pairs, with a valid/ready result port that holds one block result.
module sad_accumulator
  import me_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int unsigned BLOCK_LEN = DEF_BLOCK_LEN,
  localparam int unsigned ACC_WIDTH = acc_width(BIT_WIDTH, BLOCK_LEN)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] element0,
  input  logic [BIT_WIDTH-1:0] element1,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] sad
);

  localparam int unsigned CNT_WIDTH = $clog2(BLOCK_LEN);
  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(BLOCK_LEN - 1);

  logic [ACC_WIDTH-1:0] r_acc, w_acc_d;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt_d;
  logic [ACC_WIDTH-1:0] r_sad, w_sad_d;
  logic                 r_out_valid, w_out_valid_d;

  logic [BIT_WIDTH-1:0] w_diff;
  logic [ACC_WIDTH-1:0] w_sum;
  logic                 w_accept;

  abs_diff #(
    .BIT_WIDTH(BIT_WIDTH)
  ) u_abs_diff (
    .element0(element0),
    .element1(element1),
    .element (w_diff)
  );

  // A pending result blocks input only while downstream is stalling.
  assign in_ready = ~r_out_valid | out_ready;
  assign w_accept = in_valid & in_ready;
  assign w_sum    = r_acc + ACC_WIDTH'(w_diff);

  always_comb begin
    w_acc_d       = r_acc;
    w_cnt_d       = r_cnt;
    w_sad_d       = r_sad;
    w_out_valid_d = r_out_valid;

    if (r_out_valid && out_ready) begin
      w_out_valid_d = 1'b0;
    end

    // clear drops the partial block and any pair arriving with it, but never
    // the result already waiting on the output.
    if (clear) begin
      w_acc_d = '0;
      w_cnt_d = '0;
    end else if (w_accept) begin
      if (r_cnt == LAST_IDX) begin
        w_sad_d       = w_sum;
        w_out_valid_d = 1'b1;
        w_acc_d       = '0;
        w_cnt_d       = '0;
      end else begin
        w_acc_d = w_sum;
        w_cnt_d = r_cnt + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_sad       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_acc       <= w_acc_d;
      r_cnt       <= w_cnt_d;
      r_sad       <= w_sad_d;
      r_out_valid <= w_out_valid_d;
    end
  end

  assign out_valid = r_out_valid;
  assign sad       = r_sad;

endmodule

// File: tb/tb_sad_accumulator.sv
// Self-checking bench for sad_accumulator (BIT_WIDTH=14, BLOCK_LEN=4).
module tb_sad_accumulator;

  localparam int unsigned BW  = 14;
  localparam int unsigned LEN = 4;
  localparam int unsigned AW  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] element0 = '0;
  logic [BW-1:0] element1 = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [AW-1:0] sad;

  logic [BW-1:0] ad_a = '0;
  logic [BW-1:0] ad_b = '0;
  logic [BW-1:0] ad_y;

  int n_cmp  = 0;
  int n_fail = 0;

  sad_accumulator #(
    .BIT_WIDTH(BW),
    .BLOCK_LEN(LEN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .element0 (element0),
    .element1 (element1),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sad      (sad)
  );

  abs_diff #(
    .BIT_WIDTH(BW)
  ) u_ad (
    .element0(ad_a),
    .element1(ad_b),
    .element (ad_y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: block sum of |a-b| over accepted pairs, one held result.
  int m_cnt, m_sum, m_sad;
  bit m_valid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_sum = 0; m_sad = 0; m_valid = 0;
    end else begin
      bit rdy;
      int a, b;
      rdy = !m_valid || out_ready;
      if (m_valid && out_ready) m_valid = 0;
      if (clear) begin
        m_cnt = 0; m_sum = 0;
      end else if (in_valid && rdy) begin
        a = int'(element0);
        b = int'(element1);
        m_sum += (a > b) ? a - b : b - a;
        m_cnt++;
        if (m_cnt == LEN) begin
          m_sad = m_sum; m_valid = 1; m_sum = 0; m_cnt = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("out_valid", longint'(out_valid), longint'(m_valid));
    chk("in_ready", longint'(in_ready), longint'(!rst_n ? 1'b1 : (!m_valid || out_ready)));
    chk("sad", longint'(sad), longint'(m_sad));
  end

  // Present one pair and hold it until accepted (bounded); returns at edge+1.
  task automatic send(input int a, input int b, input bit clr);
    bit done;
    done = 0;
    element0 = BW'(a);
    element1 = BW'(b);
    in_valid = 1'b1;
    clear = clr;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    clear = 1'b0;
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: pair (%0d,%0d) not accepted, required accept", a, b);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int va[6];
    int vb[6];
    va = '{0, 16383, 5, 100, 16383, 7};
    vb = '{16383, 0, 5, 101, 16382, 0};
    foreach (va[i]) begin
      ad_a = BW'(va[i]);
      ad_b = BW'(vb[i]);
      #1;
      chk("abs_diff", longint'(ad_y), longint'((va[i] > vb[i]) ? va[i] - vb[i] : vb[i] - va[i]));
    end

    // Reset
    repeat (2) cycle();
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_sad", longint'(sad), 0);
    rst_n = 1'b1;
    cycle();
    chk("rst_in_ready", longint'(in_ready), 1);

    // Basic block
    send(10, 3, 0); send(3, 10, 0); send(0, 0, 0); send(16383, 0, 0);
    chk("basic_valid", longint'(out_valid), 1);
    chk("basic_sad", longint'(sad), 16397);
    cycle();
    chk("basic_drop", longint'(out_valid), 0);

    // Max magnitude
    repeat (4) send(16383, 0, 0);
    chk("max_sad", longint'(sad), 65532);
    cycle();

    // Backpressure
    out_ready = 1'b0;
    repeat (4) send(1, 2, 0);
    chk("bp_valid", longint'(out_valid), 1);
    chk("bp_sad", longint'(sad), 4);
    element0 = BW'(3); element1 = '0; in_valid = 1'b1;
    repeat (3) begin
      cycle();
      chk("bp_in_ready", longint'(in_ready), 0);
      chk("bp_sad_hold", longint'(sad), 4);
    end
    out_ready = 1'b1;
    send(3, 0, 0);
    chk("bp_release", longint'(out_valid), 0);
    repeat (3) send(0, 0, 0);
    chk("bp_next_sad", longint'(sad), 3);
    cycle();

    // Back-to-back
    for (int i = 1; i <= 8; i++) begin
      send(5, 1, 0);
      if (i == 4 || i == 8) begin
        chk("b2b_valid", longint'(out_valid), 1);
        chk("b2b_sad", longint'(sad), 16);
      end else if (i == 5) begin
        chk("b2b_gap", longint'(out_valid), 0);
      end
    end
    cycle();

    // Clear
    send(9, 1, 0); send(9, 1, 0); send(9, 1, 1);
    chk("clr_no_result", longint'(out_valid), 0);
    repeat (3) send(2, 1, 0);
    chk("clr_partial", longint'(out_valid), 0);
    send(2, 1, 0);
    chk("clr_valid", longint'(out_valid), 1);
    chk("clr_sad", longint'(sad), 4);
    cycle();

    // Async reset mid-block, then mid-hold
    send(1, 0, 0); send(1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_blk_valid", longint'(out_valid), 0);
    chk("arst_blk_sad", longint'(sad), 0);
    cycle();
    rst_n = 1'b1;
    out_ready = 1'b0;
    repeat (4) send(3, 0, 0);
    chk("hold_sad", longint'(sad), 12);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hold_valid", longint'(out_valid), 0);
    chk("arst_hold_sad", longint'(sad), 0);
    cycle();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) send(1, 0, 0);
    chk("post_rst_valid", longint'(out_valid), 1);
    chk("post_rst_sad", longint'(sad), 4);
    repeat (2) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
